sync_fifo_fwft: RTL and testbench

//  Single-clock FIFO, parametrised width/depth, selectable standard or first-word-fall-through read mode.

---
 rtl/sync_fifo_pkg.sv | 26 ++
 rtl/sync_fifo_sdp_ram.sv | 28 ++
 rtl/sync_fifo_fwft.sv | 99 +++++++++
 tb/tb_sync_fifo_fwft.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration helpers for the single-clock FWFT-capable FIFO.
package sync_fifo_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RESET = '{
    full:         1'b0,
    almost_full:  1'b0,
    empty:        1'b1,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module sdp_ram #(
  parameter int unsigned W = 16,
  parameter int unsigned D = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [$clog2(D)-1:0] waddr,
  input  logic [W-1:0]         wdata,
  input  logic                 re,
  input  logic [$clog2(D)-1:0] raddr,
  output logic [W-1:0]         rdata
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register doubles as the FIFO output register, so it holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy and sticky error flags.
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned D    = 1024,
  parameter int unsigned FWFT = 0,
  parameter int unsigned AF   = D - 4,
  parameter int unsigned AE   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       din,
  input  logic               wr_en,
  output logic               full,
  output logic               almost_full,
  input  logic               rd_en,
  output logic [W-1:0]       dout,
  output logic               empty,
  output logic               almost_empty,
  output logic [$clog2(D):0] count,
  output logic               overflow,
  output logic               underflow
);

  localparam int unsigned AW = $clog2(D);
  localparam int unsigned CW = AW + 1;

  if (!is_pow2(D) || D < 4) begin : g_bad_depth
    $error("sync_fifo_fwft: D must be a power of two and >= 4");
  end

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_nxt;
  logic          out_valid, valid_nxt;
  logic          wr_acc, rd_acc, ram_re, ram_has;
  fifo_status_t  st_q, st_nxt;

  // In FWFT mode rd_ptr tracks the RAM side only; the word on dout is already
  // out of the RAM but still counted, so RAM holds count - out_valid words.
  always_comb begin
    wr_acc    = wr_en && !st_q.full;
    rd_acc    = rd_en && !st_q.empty;
    ram_has   = (wr_ptr != rd_ptr);
    ram_re    = (FWFT != 0) ? (ram_has && (!out_valid || rd_acc)) : rd_acc;
    valid_nxt = ram_re ? 1'b1 : (rd_acc ? 1'b0 : out_valid);

    count_nxt = count_q;
    if (wr_acc && !rd_acc)      count_nxt = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_nxt = count_q - CW'(1);

    st_nxt              = st_q;
    st_nxt.full         = (count_nxt == CW'(D));
    st_nxt.almost_full  = (count_nxt >= CW'(AF));
    st_nxt.empty        = (FWFT != 0) ? !valid_nxt : (count_nxt == '0);
    st_nxt.almost_empty = (count_nxt <= CW'(AE));
    st_nxt.overflow     = st_q.overflow  | (wr_en & st_q.full);
    st_nxt.underflow    = st_q.underflow | (rd_en & st_q.empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      out_valid <= 1'b0;
      st_q      <= STATUS_RESET;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (ram_re) rd_ptr <= rd_ptr + 1'b1;
      count_q   <= count_nxt;
      out_valid <= valid_nxt;
      st_q      <= st_nxt;
    end
  end

  sdp_ram #(
    .W (W),
    .D (D)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din),
    .re    (ram_re),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (dout)
  );

  assign full         = st_q.full;
  assign almost_full  = st_q.almost_full;
  assign empty        = st_q.empty;
  assign almost_empty = st_q.almost_empty;
  assign overflow     = st_q.overflow;
  assign underflow    = st_q.underflow;
  assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed and scoreboard checks of sync_fifo_fwft in standard (index 0) and FWFT (index 1) modes.
module tb_sync_fifo_fwft;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset        [2];
  logic [15:0] din          [2];
  logic        wr_en        [2];
  logic        rd_en        [2];
  logic        full         [2];
  logic        almost_full  [2];
  logic        empty        [2];
  logic        almost_empty [2];
  logic        overflow     [2];
  logic        underflow    [2];
  logic [15:0] dout         [2];
  logic [4:0]  count        [2];

  sync_fifo_fwft #(.W(16), .D(16), .FWFT(0), .AF(12), .AE(2)) u_std (
    .clk(clk), .reset(reset[0]), .din(din[0]), .wr_en(wr_en[0]), .full(full[0]),
    .almost_full(almost_full[0]), .rd_en(rd_en[0]), .dout(dout[0]), .empty(empty[0]),
    .almost_empty(almost_empty[0]), .count(count[0]), .overflow(overflow[0]),
    .underflow(underflow[0])
  );

  sync_fifo_fwft #(.W(16), .D(16), .FWFT(1), .AF(12), .AE(2)) u_fwft (
    .clk(clk), .reset(reset[1]), .din(din[1]), .wr_en(wr_en[1]), .full(full[1]),
    .almost_full(almost_full[1]), .rd_en(rd_en[1]), .dout(dout[1]), .empty(empty[1]),
    .almost_empty(almost_empty[1]), .count(count[1]), .overflow(overflow[1]),
    .underflow(underflow[1])
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int          m_cur   = 0;

  logic [15:0] mq[$];
  bit          mvalid, movf, munf;
  logic [15:0] mdout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL mode%0d %s: got 0x%0h expected 0x%0h", m_cur, tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mq.delete();
    mvalid = 1'b0;
    movf   = 1'b0;
    munf   = 1'b0;
    mdout  = '0;
  endtask

  task automatic do_reset(input int m);
    reset[m] = 1'b1;
    wr_en[m] = 1'b0;
    rd_en[m] = 1'b0;
    din[m]   = '0;
    tick();
    tick();
    reset[m] = 1'b0;
    tick();
    model_clear();
  endtask

  task automatic drive(input int m, input bit wr, input bit rd, input logic [15:0] d);
    wr_en[m] = wr;
    rd_en[m] = rd;
    din[m]   = d;
  endtask

  // One clock of traffic against the scoreboard model, then a full output check.
  task automatic cyc(input int m, input bit wr, input bit rd, input logic [15:0] d);
    bit wacc, racc, readable, loaded;
    int ram_words;
    drive(m, wr, rd, d);
    readable  = (m == 0) ? (mq.size() > 0) : mvalid;
    wacc      = wr && (mq.size() < 16);
    racc      = rd && readable;
    if (wr && mq.size() == 16) movf = 1'b1;
    if (rd && !readable)       munf = 1'b1;
    ram_words = mq.size() - int'(mvalid);
    if (m == 1) begin
      loaded = (ram_words > 0) && (!mvalid || racc);
      mvalid = loaded ? 1'b1 : (racc ? 1'b0 : mvalid);
    end
    if (racc) mdout = mq.pop_front();
    if (wacc) mq.push_back(d);
    tick();
    drive(m, 1'b0, 1'b0, '0);
    check("count", 32'(count[m]), 32'(mq.size()));
    check("empty", 32'(empty[m]), 32'((m == 0) ? (mq.size() == 0) : !mvalid));
    check("full", 32'(full[m]), 32'(mq.size() == 16));
    check("almost_full", 32'(almost_full[m]), 32'(mq.size() >= 12));
    check("almost_empty", 32'(almost_empty[m]), 32'(mq.size() <= 2));
    check("overflow", 32'(overflow[m]), 32'(movf));
    check("underflow", 32'(underflow[m]), 32'(munf));
    if (m == 0)     check("dout", 32'(dout[m]), 32'(mdout));
    else if (mvalid) check("dout_head", 32'(dout[m]), 32'(mq[0]));
  endtask

  task automatic check_reset_state(input int m, input string pfx);
    check({pfx, "_empty"}, 32'(empty[m]), 32'(1));
    check({pfx, "_almost_empty"}, 32'(almost_empty[m]), 32'(1));
    check({pfx, "_full"}, 32'(full[m]), 32'(0));
    check({pfx, "_almost_full"}, 32'(almost_full[m]), 32'(0));
    check({pfx, "_count"}, 32'(count[m]), 32'(0));
    check({pfx, "_overflow"}, 32'(overflow[m]), 32'(0));
    check({pfx, "_underflow"}, 32'(underflow[m]), 32'(0));
    check({pfx, "_dout"}, 32'(dout[m]), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b0;
      drive(i, 1'b0, 1'b0, '0);
    end

    for (int m = 0; m < 2; m++) begin
      m_cur = m;

      // reset then idle
      do_reset(m);
      repeat (10) tick();
      check_reset_state(m, "rst");

      // fill past full
      for (int i = 1; i <= 16; i++) begin
        drive(m, 1'b1, 1'b0, 16'(i));
        tick();
        check("fill_count", 32'(count[m]), 32'(i));
        check("fill_af", 32'(almost_full[m]), 32'(i >= 12));
        check("fill_full", 32'(full[m]), 32'(i == 16));
        check("fill_empty", 32'(empty[m]), 32'((m == 0) ? 0 : (i < 2)));
      end
      drive(m, 1'b1, 1'b0, 16'hBEEF);
      tick();
      drive(m, 1'b0, 1'b0, '0);
      check("ovf_count", 32'(count[m]), 32'(16));
      check("ovf_flag", 32'(overflow[m]), 32'(1));
      check("ovf_full", 32'(full[m]), 32'(1));

      // drain in order
      drive(m, 1'b0, 1'b1, '0);
      for (int i = 1; i <= 16; i++) begin
        if (m == 1) check("drain_head", 32'(dout[m]), 32'(i));
        tick();
        if (m == 0) check("drain_dout", 32'(dout[m]), 32'(i));
        check("drain_count", 32'(count[m]), 32'(16 - i));
        check("drain_ae", 32'(almost_empty[m]), 32'((16 - i) <= 2));
      end
      drive(m, 1'b0, 1'b0, '0);
      check("drain_empty", 32'(empty[m]), 32'(1));
      check("drain_unf", 32'(underflow[m]), 32'(0));

      // read while empty
      drive(m, 1'b0, 1'b1, '0);
      tick();
      drive(m, 1'b0, 1'b0, '0);
      check("unf_flag", 32'(underflow[m]), 32'(1));
      check("unf_count", 32'(count[m]), 32'(0));
      check("unf_dout", 32'(dout[m]), 32'(16'h0010));
      repeat (5) tick();
      check("unf_sticky", 32'(underflow[m]), 32'(1));

      // single-word latency
      do_reset(m);
      drive(m, 1'b1, 1'b0, 16'h00A5);
      tick();
      drive(m, 1'b0, 1'b0, '0);
      check("lat_count", 32'(count[m]), 32'(1));
      check("lat_empty_n", 32'(empty[m]), 32'((m == 0) ? 0 : 1));
      if (m == 0) begin
        check("lat_dout_pre", 32'(dout[m]), 32'(0));
        drive(m, 1'b0, 1'b1, '0);
        tick();
        drive(m, 1'b0, 1'b0, '0);
        check("lat_dout", 32'(dout[m]), 32'(16'h00A5));
        check("lat_empty_after", 32'(empty[m]), 32'(1));
      end else begin
        tick();
        check("lat_empty_n1", 32'(empty[m]), 32'(0));
        check("lat_dout", 32'(dout[m]), 32'(16'h00A5));
        drive(m, 1'b0, 1'b1, '0);
        tick();
        drive(m, 1'b0, 1'b0, '0);
        check("lat_empty_after", 32'(empty[m]), 32'(1));
        check("lat_count_after", 32'(count[m]), 32'(0));
      end

      // simultaneous read/write at full, then steady state across wrap
      do_reset(m);
      for (int i = 1; i <= 16; i++) cyc(m, 1'b1, 1'b0, 16'(i));
      cyc(m, 1'b1, 1'b1, 16'hDEAD);
      check("simul_count", 32'(count[m]), 32'(15));
      check("simul_ovf", 32'(overflow[m]), 32'(1));
      check("simul_dout", 32'(dout[m]), 32'((m == 0) ? 1 : 2));
      repeat (7) cyc(m, 1'b0, 1'b1, '0);
      check("steady_start", 32'(count[m]), 32'(8));
      for (int k = 0; k < 100; k++) cyc(m, 1'b1, 1'b1, 16'(16'h0100 + k));
      check("steady_end", 32'(count[m]), 32'(8));

      // random traffic with a mid-run reset
      do_reset(m);
      for (int c = 0; c < 20000; c++) begin
        if (c == 10000) begin
          reset[m] = 1'b1;
          #1;
          check_reset_state(m, "midrst");
          tick();
          tick();
          reset[m] = 1'b0;
          tick();
          model_clear();
        end else begin
          cyc(m, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 16'($urandom));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
